// File: rtl/btn_pkg.sv
// Shared types and timing constants for the front-panel button conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package btn_pkg;

    // Panel clock frequency; default timings below are derived from it.
    localparam int unsigned CLK_HZ = 50_000_000;

    // 20 ms debounce window, 1 s long-press threshold, 250 ms auto-repeat period.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;
    localparam int unsigned DEF_LONG_CYCLES     = CLK_HZ;
    localparam int unsigned DEF_REPEAT_CYCLES   = CLK_HZ / 4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_PRESS = 3'd1,
        DOWN       = 3'd2,
        LONG       = 3'd3,
        WAIT_REL   = 3'd4
    } btn_state_t;

endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
// Latency: 2 clk edges from input change to output change.
// Backpressure: none; the output follows the input continuously.
module btn_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; both reset to the idle level of the input.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Synchronise, debounce and classify one active-low panel button (press/release/click/long/repeat).
// Latency: press_pulse high the cycle after edge DEBOUNCE_CYCLES+2 counted from the first low sample; release symmetric.
// Backpressure: none; single-cycle pulses, auto-repeat only when BTN_AUTO_REPEAT_EN is defined.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    // Every counter below relies on thresholds of at least 2 to keep its width non-zero.
    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("button_conditioner: DEBOUNCE_CYCLES, LONG_CYCLES and REPEAT_CYCLES must all be >= 2");
    end

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic btn_n_sync;
    logic sync_dn;

    btn_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (btn_n),
        .q_o   (btn_n_sync)
    );

    assign sync_dn = ~btn_n_sync;

    btn_state_t        state_q, state_d;
    btn_state_t        ret_q,   ret_d;
    logic [DEB_W-1:0]  deb_q,   deb_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic              pressed_q, pressed_d;
    logic              press_q,   press_d;
    logic              rel_q,     rel_d;
    logic              click_q,   click_d;
    logic              long_q,    long_d;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int unsigned       REP_W    = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_ONE  = REP_W'(1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             repeat_q, repeat_d;
`endif

    // State, counters and registered outputs; reset aborts any press in progress silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ret_q     <= DOWN;
            deb_q     <= '0;
            hold_q    <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rep_q     <= '0;
            repeat_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            deb_q     <= deb_d;
            hold_q    <= hold_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
            click_q   <= click_d;
            long_q    <= long_d;
`ifdef BTN_AUTO_REPEAT_EN
            rep_q     <= rep_d;
            repeat_q  <= repeat_d;
`endif
        end
    end

    // Next-state and next-output logic; counters hold unless explicitly advanced or cleared.
    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        deb_d     = deb_q;
        hold_d    = hold_q;
        pressed_d = pressed_q;
        press_d   = 1'b0;
        rel_d     = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        rep_d     = rep_q;
        repeat_d  = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (sync_dn) begin
                    state_d = WAIT_PRESS;
                    deb_d   = DEB_ONE;
                end
            end

            WAIT_PRESS: begin
                if (!sync_dn) begin
                    // Glitch shorter than the debounce window: drop it.
                    state_d = IDLE;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d   = DOWN;
                    press_d   = 1'b1;
                    pressed_d = 1'b1;
                    hold_d    = '0;
                    deb_d     = '0;
                end else begin
                    deb_d = deb_q + DEB_ONE;
                end
            end

            DOWN: begin
                // A release sample takes priority over reaching the long threshold.
                if (!sync_dn) begin
                    state_d = WAIT_REL;
                    deb_d   = DEB_ONE;
                    ret_d   = DOWN;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                    rep_d   = '0;
`endif
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end

            LONG: begin
                // hold_q stays saturated at its threshold while in LONG.
                if (!sync_dn) begin
                    state_d = WAIT_REL;
                    deb_d   = DEB_ONE;
                    ret_d   = LONG;
                end else begin
`ifdef BTN_AUTO_REPEAT_EN
                    if (rep_q == REP_LAST) begin
                        repeat_d = 1'b1;
                        rep_d    = '0;
                    end else begin
                        rep_d = rep_q + REP_ONE;
                    end
`endif
                end
            end

            WAIT_REL: begin
                // Hold and repeat counters are frozen here so a bounce resumes where it left off.
                if (sync_dn) begin
                    state_d = ret_q;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d   = IDLE;
                    rel_d     = 1'b1;
                    click_d   = (ret_q == DOWN);
                    pressed_d = 1'b0;
                    deb_d     = '0;
                    hold_d    = '0;
`ifdef BTN_AUTO_REPEAT_EN
                    rep_d     = '0;
`endif
                end else begin
                    deb_d = deb_q + DEB_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign click_pulse   = click_q;
    assign long_pulse    = long_q;
`ifdef BTN_AUTO_REPEAT_EN
    assign repeat_pulse  = repeat_q;
`else
    assign repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short timings (debounce 4, long 20, repeat 5).
// Expected pulses are queued with the clk edge number they must follow; a monitor pops and compares.
// Edge numbers are absolute posedge counts; stimulus changes at negedges.
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned LNG = 20;
    localparam int unsigned REP = 5;

    // Pulse vector layout: {press, release, click, long, repeat}
    localparam logic [4:0] P_PRESS = 5'b10000;
    localparam logic [4:0] P_REL   = 5'b01000;
    localparam logic [4:0] P_CLICK = 5'b00100;
    localparam logic [4:0] P_LONG  = 5'b00010;
    localparam logic [4:0] P_REP   = 5'b00001;

    logic clk = 1'b0;
    logic reset;
    logic btn_n;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic click_pulse;
    logic long_pulse;
    logic repeat_pulse;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int base;

    typedef struct {
        int         cyc;
        logic [4:0] pulses;
    } ev_t;

    ev_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_n         (btn_n),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .click_pulse   (click_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    task automatic expect_ev(input int c, input logic [4:0] p);
        ev_t e;
        e.cyc    = c;
        e.pulses = p;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic monitor();
        logic [4:0] obs;
        ev_t        e;
        forever begin
            @(negedge clk);
            obs = {press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse};
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL missing_pulse: actual=none by edge %0d required=%b after edge %0d",
                         cyc, e.pulses, e.cyc);
            end
            if (obs != 5'b0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: actual=%b after edge %0d required=none", obs, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.pulses !== obs) begin
                        bad++;
                        $display("FAIL pulse_event: actual=%b after edge %0d required=%b after edge %0d",
                                 obs, cyc, e.pulses, e.cyc);
                    end
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        btn_n = 1'b1;
        fork
            monitor();
        join_none
        wait_neg(3);
        check("reset_outputs", 32'({pressed, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse}), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        reset = 1'b0;
        wait_neg(5);

        // Glitch: low for 3 samples is rejected.
        btn_n = 1'b0;
        wait_neg(3);
        btn_n = 1'b1;
        wait_neg(10);
        check("glitch_pressed", 32'(pressed), 32'd0);
        check("glitch_state", 32'(dut.state_q), 32'(IDLE));

        // Short press held 12 samples: click at release.
        base = cyc;
        btn_n = 1'b0;
        expect_ev(base + 6, P_PRESS);
        wait_neg(12);
        check("click_pressed_hi", 32'(pressed), 32'd1);
        btn_n = 1'b1;
        expect_ev(base + 18, P_REL | P_CLICK);
        wait_neg(12);
        check("click_pressed_lo", 32'(pressed), 32'd0);

        // Long press held 40 samples.
        base = cyc;
        btn_n = 1'b0;
        expect_ev(base + 6, P_PRESS);
        expect_ev(base + 26, P_LONG);
`ifdef BTN_AUTO_REPEAT_EN
        expect_ev(base + 31, P_REP);
        expect_ev(base + 36, P_REP);
        expect_ev(base + 41, P_REP);
`endif
        wait_neg(40);
        check("long_pressed_hi", 32'(pressed), 32'd1);
        btn_n = 1'b1;
        expect_ev(base + 46, P_REL);
        wait_neg(12);
        check("long_pressed_lo", 32'(pressed), 32'd0);

        // Bounce in DOWN: 2 high samples freeze hold for 3 edges, long moves 26 -> 29.
        base = cyc;
        btn_n = 1'b0;
        expect_ev(base + 6, P_PRESS);
        expect_ev(base + 29, P_LONG);
`ifdef BTN_AUTO_REPEAT_EN
        expect_ev(base + 34, P_REP);
`endif
        wait_neg(9);
        btn_n = 1'b1;
        wait_neg(2);
        btn_n = 1'b0;
        wait_neg(2);
        check("bounce_pressed", 32'(pressed), 32'd1);
        check("bounce_state", 32'(dut.state_q), 32'(WAIT_REL));
        wait_neg(22);
        btn_n = 1'b1;
        expect_ev(base + 41, P_REL);
        wait_neg(12);
        check("bounce_pressed_lo", 32'(pressed), 32'd0);

        // Reset while in LONG with the button held, then a fresh press after release of reset.
        base = cyc;
        btn_n = 1'b0;
        expect_ev(base + 6, P_PRESS);
        expect_ev(base + 26, P_LONG);
        wait_neg(28);
        check("pre_reset_state", 32'(dut.state_q), 32'(LONG));
        reset = 1'b1;
        #1;
        check("midreset_outputs", 32'({pressed, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse}), 32'd0);
        check("midreset_state", 32'(dut.state_q), 32'(IDLE));
        wait_neg(2);
        reset = 1'b0;
        base = cyc;
        check("postreset_pressed", 32'(pressed), 32'd0);
        expect_ev(base + 6, P_PRESS);
        wait_neg(10);
        check("postreset_pressed_hi", 32'(pressed), 32'd1);
        btn_n = 1'b1;
        expect_ev(base + 16, P_REL | P_CLICK);
        wait_neg(12);

        wait_neg(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
